hex_word_streamer: RTL and testbench

HEX_WORD_STREAMER -- requirements
Module: hex_word_streamer

---
 rtl/hex_word_streamer.sv | 116 +++++++++++
 tb/tb_hex_word_streamer.sv | 365 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hex_word_streamer.sv
`timescale 1ns/1ps
// Prints each accepted W-bit word as NIBBLES uppercase ASCII hex digits, MS nibble first; CR/LF trailer when HEX_WORD_STREAMER_CRLF_EN is defined.
// Latency: first character valid one cycle after acceptance, then at most one character per cycle.
// Backpressure: out_char/out_valid held while out_ready is low; in_ready only in IDLE, so words never overlap.
module hex_word_streamer #(
    parameter int NIBBLES = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [4*NIBBLES-1:0] in_data,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [7:0]           out_char,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 busy
);

    localparam int W  = 4 * NIBBLES;
    localparam int CW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

`ifdef HEX_WORD_STREAMER_CRLF_EN
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DIGIT = 2'd1,
        CR    = 2'd2,
        LF    = 2'd3
    } state_t;
`else
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DIGIT = 2'd1
    } state_t;
`endif

    state_t         state_q, state_d;
    logic [W-1:0]   shift_q, shift_d;
    logic [CW-1:0]  cnt_q,   cnt_d;

    function automatic logic [7:0] hex_ascii(input logic [3:0] nib);
        if (nib < 4'd10) begin
            return 8'h30 + {4'h0, nib};
        end
        return 8'h37 + {4'h0, nib};
    endfunction

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        cnt_d     = cnt_q;
        in_ready  = (state_q == IDLE) && !rst;
        out_valid = 1'b0;
        out_char  = 8'h00;
        busy      = (state_q != IDLE);

        case (state_q)
            IDLE: begin
                if (in_valid && in_ready) begin
                    shift_d = in_data;
                    cnt_d   = CW'(NIBBLES - 1);
                    state_d = DIGIT;
                end
            end
            DIGIT: begin
                out_valid = 1'b1;
                out_char  = hex_ascii(shift_q[W-1 -: 4]);
                if (out_ready) begin
                    shift_d = shift_q << 4;
                    if (cnt_q == '0) begin
                        cnt_d   = '0;
`ifdef HEX_WORD_STREAMER_CRLF_EN
                        state_d = CR;
`else
                        state_d = IDLE;
`endif
                    end else begin
                        cnt_d = cnt_q - CW'(1);
                    end
                end
            end
`ifdef HEX_WORD_STREAMER_CRLF_EN
            CR: begin
                out_valid = 1'b1;
                out_char  = 8'h0D;
                if (out_ready) begin
                    state_d = LF;
                end
            end
            LF: begin
                out_valid = 1'b1;
                out_char  = 8'h0A;
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
`endif
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Reset also discards any partially printed word.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            shift_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_hex_word_streamer.sv
`timescale 1ns/1ps
// Directed bench for hex_word_streamer: 8-, 2- and 1-digit instances, expected ASCII streams written out by hand.
module tb_hex_word_streamer;

`ifdef HEX_WORD_STREAMER_CRLF_EN
    localparam bit CRLF = 1'b1;
`else
    localparam bit CRLF = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;

    logic [31:0] in_data8;
    logic        in_valid8, in_ready8, out_valid8, out_ready8, busy8;
    logic [7:0]  out_char8;

    logic [7:0]  in_data2;
    logic        in_valid2, in_ready2, out_valid2, out_ready2, busy2;
    logic [7:0]  out_char2;

    logic [3:0]  in_data1;
    logic        in_valid1, in_ready1, out_valid1, out_ready1, busy1;
    logic [7:0]  out_char1;

    int vectors     = 0;
    int miscompares = 0;

    hex_word_streamer #(.NIBBLES(8)) dut8 (
        .clk(clk), .rst(rst),
        .in_data(in_data8), .in_valid(in_valid8), .in_ready(in_ready8),
        .out_char(out_char8), .out_valid(out_valid8), .out_ready(out_ready8),
        .busy(busy8)
    );

    hex_word_streamer #(.NIBBLES(2)) dut2 (
        .clk(clk), .rst(rst),
        .in_data(in_data2), .in_valid(in_valid2), .in_ready(in_ready2),
        .out_char(out_char2), .out_valid(out_valid2), .out_ready(out_ready2),
        .busy(busy2)
    );

    hex_word_streamer #(.NIBBLES(1)) dut1 (
        .clk(clk), .rst(rst),
        .in_data(in_data1), .in_valid(in_valid1), .in_ready(in_ready1),
        .out_char(out_char1), .out_valid(out_valid1), .out_ready(out_ready1),
        .busy(busy1)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst        = 1'b1;
        in_data8   = 32'h1234_5678;
        in_valid8  = 1'b1;
        in_data2   = 8'h55;
        in_valid2  = 1'b1;
        in_data1   = 4'h5;
        in_valid1  = 1'b1;
        out_ready8 = 1'b1;
        out_ready2 = 1'b1;
        out_ready1 = 1'b1;
        step();
        step();
        vectors++;
        if (out_valid8 !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_out_valid: got %b want 0", out_valid8);
        end
        vectors++;
        if (out_char8 !== 8'h00) begin
            miscompares++;
            $display("FAIL reset_out_char: got %h want 00", out_char8);
        end
        vectors++;
        if (busy8 !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_busy: got %b want 0", busy8);
        end
        vectors++;
        if (in_ready8 !== 1'b0 || in_ready2 !== 1'b0 || in_ready1 !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_in_ready_held: got %b%b%b want 000", in_ready8, in_ready2, in_ready1);
        end
        in_valid8 = 1'b0;
        in_valid2 = 1'b0;
        in_valid1 = 1'b0;
        rst       = 1'b0;
        #1;
        vectors++;
        if (in_ready8 !== 1'b1 || busy8 !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_release: got in_ready=%b busy=%b want 1 0", in_ready8, busy8);
        end
    endtask

    task automatic test_basic();
        logic [7:0] exp[$];
        exp = {8'h31, 8'h32, 8'h33, 8'h34, 8'h41, 8'h42, 8'h43, 8'h44};
        if (CRLF) begin
            exp.push_back(8'h0D);
            exp.push_back(8'h0A);
        end
        out_ready8 = 1'b1;
        in_data8   = 32'h1234_ABCD;
        in_valid8  = 1'b1;
        vectors++;
        if (in_ready8 !== 1'b1) begin
            miscompares++;
            $display("FAIL basic_in_ready: got %b want 1", in_ready8);
        end
        step();
        in_valid8 = 1'b0;
        in_data8  = 32'hFFFF_0000;
        for (int i = 0; i < exp.size(); i++) begin
            vectors++;
            if (out_valid8 !== 1'b1 || out_char8 !== exp[i]) begin
                miscompares++;
                $display("FAIL basic_char[%0d]: got valid=%b char=%h want 1 %h", i, out_valid8, out_char8, exp[i]);
            end
            step();
        end
        vectors++;
        if (out_valid8 !== 1'b0 || out_char8 !== 8'h00 || busy8 !== 1'b0 || in_ready8 !== 1'b1) begin
            miscompares++;
            $display("FAIL basic_idle: got valid=%b char=%h busy=%b in_ready=%b want 0 00 0 1",
                     out_valid8, out_char8, busy8, in_ready8);
        end
    endtask

    task automatic test_stall();
        logic [7:0] exp[$];
        logic [7:0] prev_char;
        bit         prev_stalled;
        int         idx;
        int         cyc;
        exp = {8'h30, 8'h30, 8'h30, 8'h30, 8'h46, 8'h46, 8'h46, 8'h46};
        if (CRLF) begin
            exp.push_back(8'h0D);
            exp.push_back(8'h0A);
        end
        idx          = 0;
        cyc          = 0;
        prev_char    = 8'h00;
        prev_stalled = 1'b0;
        out_ready8   = 1'b1;
        in_data8     = 32'h0000_FFFF;
        in_valid8    = 1'b1;
        step();
        in_valid8 = 1'b0;
        while (idx < exp.size() && cyc < 80) begin
            vectors++;
            if (out_valid8 !== 1'b1 || out_char8 !== exp[idx]) begin
                miscompares++;
                $display("FAIL stall_char[%0d]: got valid=%b char=%h want 1 %h", idx, out_valid8, out_char8, exp[idx]);
            end
            if (prev_stalled) begin
                vectors++;
                if (out_char8 !== prev_char) begin
                    miscompares++;
                    $display("FAIL stall_hold: got %h want %h", out_char8, prev_char);
                end
            end
            out_ready8   = (cyc % 2 == 1);
            prev_char    = out_char8;
            prev_stalled = !out_ready8;
            if (out_ready8) idx++;
            step();
            cyc++;
        end
        out_ready8 = 1'b1;
        vectors++;
        if (idx != exp.size() || out_valid8 !== 1'b0 || in_ready8 !== 1'b1) begin
            miscompares++;
            $display("FAIL stall_done: got chars=%0d valid=%b in_ready=%b want %0d 0 1",
                     idx, out_valid8, in_ready8, exp.size());
        end
    endtask

    task automatic test_reset_abort();
        logic [7:0] exp[$];
        logic [7:0] head[$];
        exp  = {8'h30, 8'h30, 8'h30, 8'h30, 8'h30, 8'h30, 8'h30, 8'h31};
        head = {8'h44, 8'h45, 8'h41};
        if (CRLF) begin
            exp.push_back(8'h0D);
            exp.push_back(8'h0A);
        end
        out_ready8 = 1'b1;
        in_data8   = 32'hDEAD_BEEF;
        in_valid8  = 1'b1;
        step();
        in_valid8 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            vectors++;
            if (out_valid8 !== 1'b1 || out_char8 !== head[i]) begin
                miscompares++;
                $display("FAIL abort_head[%0d]: got valid=%b char=%h want 1 %h", i, out_valid8, out_char8, head[i]);
            end
            if (i == 2) rst = 1'b1;
            step();
        end
        vectors++;
        if (out_valid8 !== 1'b0 || busy8 !== 1'b0 || out_char8 !== 8'h00 || in_ready8 !== 1'b0) begin
            miscompares++;
            $display("FAIL abort_after_rst: got valid=%b busy=%b char=%h in_ready=%b want 0 0 00 0",
                     out_valid8, busy8, out_char8, in_ready8);
        end
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            vectors++;
            if (out_valid8 !== 1'b0 || in_ready8 !== 1'b1) begin
                miscompares++;
                $display("FAIL abort_quiet[%0d]: got valid=%b in_ready=%b want 0 1", i, out_valid8, in_ready8);
            end
        end
        in_data8  = 32'h0000_0001;
        in_valid8 = 1'b1;
        step();
        in_valid8 = 1'b0;
        for (int i = 0; i < exp.size(); i++) begin
            vectors++;
            if (out_valid8 !== 1'b1 || out_char8 !== exp[i]) begin
                miscompares++;
                $display("FAIL abort_next[%0d]: got valid=%b char=%h want 1 %h", i, out_valid8, out_char8, exp[i]);
            end
            step();
        end
        vectors++;
        if (out_valid8 !== 1'b0 || busy8 !== 1'b0) begin
            miscompares++;
            $display("FAIL abort_next_idle: got valid=%b busy=%b want 0 0", out_valid8, busy8);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp[$];
        logic [7:0] got[$];
        int         accepts;
        int         idle_cycles;
        int         cyc;
        exp = {8'h41, 8'h35, 8'h41, 8'h35, 8'h41, 8'h35, 8'h41, 8'h35};
        if (CRLF) begin
            exp.push_back(8'h0D);
            exp.push_back(8'h0A);
        end
        exp = {exp, 8'h35, 8'h41, 8'h35, 8'h41, 8'h35, 8'h41, 8'h35, 8'h41};
        if (CRLF) begin
            exp.push_back(8'h0D);
            exp.push_back(8'h0A);
        end
        accepts     = 0;
        idle_cycles = 0;
        cyc         = 0;
        out_ready8  = 1'b1;
        in_data8    = 32'hA5A5_A5A5;
        in_valid8   = 1'b1;
        while (got.size() < exp.size() && cyc < 100) begin
            if (out_valid8 && out_ready8) got.push_back(out_char8);
            if (in_ready8) idle_cycles++;
            if (in_ready8 && in_valid8) accepts++;
            step();
            cyc++;
            if (accepts == 1) in_data8 = 32'h5A5A_5A5A;
            if (accepts == 2) in_valid8 = 1'b0;
        end
        in_valid8 = 1'b0;
        vectors++;
        if (accepts != 2 || idle_cycles != 2) begin
            miscompares++;
            $display("FAIL b2b_accepts: got accepts=%0d idle=%0d want 2 2", accepts, idle_cycles);
        end
        vectors++;
        if (got.size() != exp.size()) begin
            miscompares++;
            $display("FAIL b2b_count: got %0d want %0d", got.size(), exp.size());
        end
        for (int i = 0; i < exp.size() && i < got.size(); i++) begin
            vectors++;
            if (got[i] !== exp[i]) begin
                miscompares++;
                $display("FAIL b2b_char[%0d]: got %h want %h", i, got[i], exp[i]);
            end
        end
        step();
        vectors++;
        if (in_ready8 !== 1'b1 || busy8 !== 1'b0) begin
            miscompares++;
            $display("FAIL b2b_idle: got in_ready=%b busy=%b want 1 0", in_ready8, busy8);
        end
    endtask

    task automatic test_small();
        logic [7:0] exp2[$];
        logic [7:0] exp1[$];
        exp2 = {8'h39, 8'h46};
        exp1 = {8'h43};
        if (CRLF) begin
            exp2.push_back(8'h0D);
            exp2.push_back(8'h0A);
            exp1.push_back(8'h0D);
            exp1.push_back(8'h0A);
        end
        out_ready2 = 1'b1;
        in_data2   = 8'h9F;
        in_valid2  = 1'b1;
        step();
        in_valid2 = 1'b0;
        for (int i = 0; i < exp2.size(); i++) begin
            vectors++;
            if (out_valid2 !== 1'b1 || out_char2 !== exp2[i]) begin
                miscompares++;
                $display("FAIL n2_char[%0d]: got valid=%b char=%h want 1 %h", i, out_valid2, out_char2, exp2[i]);
            end
            step();
        end
        vectors++;
        if (out_valid2 !== 1'b0 || in_ready2 !== 1'b1 || busy2 !== 1'b0) begin
            miscompares++;
            $display("FAIL n2_idle: got valid=%b in_ready=%b busy=%b want 0 1 0", out_valid2, in_ready2, busy2);
        end
        out_ready1 = 1'b1;
        in_data1   = 4'hC;
        in_valid1  = 1'b1;
        step();
        in_valid1 = 1'b0;
        for (int i = 0; i < exp1.size(); i++) begin
            vectors++;
            if (out_valid1 !== 1'b1 || out_char1 !== exp1[i]) begin
                miscompares++;
                $display("FAIL n1_char[%0d]: got valid=%b char=%h want 1 %h", i, out_valid1, out_char1, exp1[i]);
            end
            step();
        end
        vectors++;
        if (out_valid1 !== 1'b0 || in_ready1 !== 1'b1 || out_char1 !== 8'h00) begin
            miscompares++;
            $display("FAIL n1_idle: got valid=%b in_ready=%b char=%h want 0 1 00", out_valid1, in_ready1, out_char1);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_reset_abort();
        test_back_to_back();
        test_small();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
